// File: rtl/uzorak_punjac.sv
// Producer for the neuron's uzorak bus: packs a stream of sample words into the vector,
// waits for the neuron output to settle, then hands out the probability and mine flag.
module uzorak_punjac #(
  parameter int          BROJ_ULAZA = 60,
  parameter int          SIRINA     = 16,
  parameter int          LATENCIJA  = 2,
  parameter logic [15:0] PRAG       = 16'h8000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SIRINA-1:0]            ulaz_podatak,
  input  logic                         ulaz_valid,
  input  logic                         ulaz_zadnji,
  output logic                         ulaz_ready,
  output logic [BROJ_ULAZA*SIRINA-1:0] uzorak,
  input  logic [15:0]                  izlaz_neurona,
  output logic                         rez_valid,
  input  logic                         rez_ready,
  output logic [15:0]                  rez_vjerojatnost,
  output logic                         rez_mina,
  output logic                         greska
);

  localparam int KW = (BROJ_ULAZA > 1) ? $clog2(BROJ_ULAZA) : 1;
  localparam int LW = (LATENCIJA > 1) ? $clog2(LATENCIJA) : 1;

  localparam logic [KW-1:0] K_ZADNJI = KW'(BROJ_ULAZA - 1);
  localparam logic [LW-1:0] LAT_POC  = LW'(LATENCIJA - 1);

  localparam logic [1:0] PUNJENJE = 2'd0;
  localparam logic [1:0] CEKANJE  = 2'd1;
  localparam logic [1:0] REZULTAT = 2'd2;

  logic [1:0]        stanje_r;
  logic [1:0]        stanje_s;
  logic [KW-1:0]     k_r;
  logic [LW-1:0]     lat_r;
  logic [SIRINA-1:0] slot_r [BROJ_ULAZA];
  logic              ready_r;
  logic              valid_r;
  logic              greska_r;
  logic [15:0]       vjer_r;
  logic              mina_r;
  logic              prihvat_s;
  logic              kraj_s;
  logic              greska_s;
  logic              hvatanje_s;

  // Next-state decode: frame completion, framing errors and result capture.
  always_comb begin
    stanje_s   = stanje_r;
    prihvat_s  = ulaz_valid & ready_r;
    kraj_s     = 1'b0;
    greska_s   = 1'b0;
    hvatanje_s = 1'b0;
    case (stanje_r)
      PUNJENJE: begin
        if (prihvat_s && (k_r == K_ZADNJI) && ulaz_zadnji) begin
          kraj_s   = 1'b1;
          stanje_s = CEKANJE;
        end else if (prihvat_s && ((k_r == K_ZADNJI) || ulaz_zadnji)) begin
          greska_s = 1'b1;
        end else begin
          stanje_s = PUNJENJE;
        end
      end
      CEKANJE: begin
        if (lat_r == {LW{1'b0}}) begin
          hvatanje_s = 1'b1;
          stanje_s   = REZULTAT;
        end else begin
          stanje_s = CEKANJE;
        end
      end
      REZULTAT: begin
        if (rez_ready) begin
          stanje_s = PUNJENJE;
        end else begin
          stanje_s = REZULTAT;
        end
      end
      default: stanje_s = PUNJENJE;
    endcase
  end

  // State, counters, sample slots and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stanje_r <= PUNJENJE;
      k_r      <= {KW{1'b0}};
      lat_r    <= {LW{1'b0}};
      slot_r   <= '{default: {SIRINA{1'b0}}};
      ready_r  <= 1'b0;
      valid_r  <= 1'b0;
      greska_r <= 1'b0;
      vjer_r   <= 16'h0000;
      mina_r   <= 1'b0;
    end else begin
      stanje_r <= stanje_s;
      // Handshake flags follow the state being entered so they line up with it.
      ready_r  <= (stanje_s == PUNJENJE);
      valid_r  <= (stanje_s == REZULTAT);
      greska_r <= greska_s;
      if (prihvat_s) begin
        slot_r[k_r] <= ulaz_podatak;
      end
      if (kraj_s || greska_s) begin
        k_r <= {KW{1'b0}};
      end else if (prihvat_s) begin
        k_r <= k_r + KW'(1'b1);
      end
      if (kraj_s) begin
        lat_r <= LAT_POC;
      end else if ((stanje_r == CEKANJE) && (lat_r != {LW{1'b0}})) begin
        lat_r <= lat_r - LW'(1'b1);
      end
      if (hvatanje_s) begin
        vjer_r <= izlaz_neurona;
        mina_r <= (izlaz_neurona >= PRAG);
      end
    end
  end

  for (genvar g = 0; g < BROJ_ULAZA; g++) begin : g_pak
    assign uzorak[g*SIRINA +: SIRINA] = slot_r[g];
  end

  assign ulaz_ready       = ready_r;
  assign rez_valid        = valid_r;
  assign greska           = greska_r;
  assign rez_vjerojatnost = vjer_r;
  assign rez_mina         = mina_r;

endmodule

// File: tb/tb_uzorak_punjac.sv
// Randomised bench for uzorak_punjac: a frame-level model feeds a scoreboard that a
// negedge monitor drains whenever the block presents a result or a framing error.
module tb_uzorak_punjac;

  localparam int N   = 60;
  localparam int W   = 16;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   ulaz_podatak;
  logic           ulaz_valid;
  logic           ulaz_zadnji;
  logic           ulaz_ready;
  logic [N*W-1:0] uzorak;
  logic [15:0]    izlaz_neurona;
  logic           rez_valid;
  logic           rez_ready;
  logic [15:0]    rez_vjerojatnost;
  logic           rez_mina;
  logic           greska;

  uzorak_punjac dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ulaz_podatak     (ulaz_podatak),
    .ulaz_valid       (ulaz_valid),
    .ulaz_zadnji      (ulaz_zadnji),
    .ulaz_ready       (ulaz_ready),
    .uzorak           (uzorak),
    .izlaz_neurona    (izlaz_neurona),
    .rez_valid        (rez_valid),
    .rez_ready        (rez_ready),
    .rez_vjerojatnost (rez_vjerojatnost),
    .rez_mina         (rez_mina),
    .greska           (greska)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] vec;
    logic [15:0]    p;
    logic           m;
    int             edge_no;
  } exp_t;

  exp_t           sb_q[$];
  int             greska_q[$];
  int             n_checks = 0;
  int             n_pass = 0;
  int             edge_count = 0;
  logic           rr_at_edge = 1'b0;
  logic [15:0]    model_slot [N];
  int             model_len = 0;
  logic [15:0]    cur_prob = 16'h0000;
  int             hold_req = 0;
  int             hold_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_vec(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    int bad;
    bad = -1;
    n_checks++;
    for (int i = N - 1; i >= 0; i--) if (act[i*W +: W] !== exp[i*W +: W]) bad = i;
    if (bad < 0) n_pass++;
    else $display("FAIL %s word %0d: got %h expected %h", nm, bad, act[bad*W +: W], exp[bad*W +: W]);
  endtask

  function automatic logic [N*W-1:0] model_vec();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = model_slot[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) model_slot[i] = 16'h0000;
    model_len = 0;
    sb_q.delete();
    greska_q.delete();
  endtask

  // Frame-level rules: a frame is exactly N words with the end marker only on the last.
  task automatic accept_model(input logic [15:0] d, input logic z, input int edg);
    exp_t e;
    model_slot[model_len] = d;
    model_len++;
    if (z && model_len == N) begin
      e.vec = model_vec();
      e.p = cur_prob;
      e.m = (cur_prob >= 16'h8000);
      e.edge_no = edg;
      sb_q.push_back(e);
      model_len = 0;
    end else if (z || model_len == N) begin
      greska_q.push_back(edg);
      model_len = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] d, input logic z, input int bubbles);
    int budget = 0;
    repeat (bubbles) begin
      tick();
      ulaz_valid = 1'b0;
      ulaz_podatak = 16'($urandom);
      ulaz_zadnji = 1'($urandom_range(0, 1));
    end
    tick();
    ulaz_valid = 1'b1;
    ulaz_podatak = d;
    ulaz_zadnji = z;
    while (ulaz_ready !== 1'b1 && budget < 300) begin
      tick();
      budget++;
    end
    if (budget >= 300) begin
      chk("ulaz_ready_timeout", 32'(ulaz_ready), 32'd1);
      ulaz_valid = 1'b0;
    end else begin
      accept_model(d, z, edge_count + 1);
    end
  endtask

  // Offers garbage marked as a frame end while the block is busy; it must be ignored.
  task automatic wait_ready();
    int budget = 0;
    ulaz_valid = 1'b1;
    ulaz_podatak = 16'($urandom);
    ulaz_zadnji = 1'b1;
    while (ulaz_ready !== 1'b1 && budget < 300) begin
      tick();
      ulaz_podatak = 16'($urandom);
      budget++;
    end
    if (budget >= 300) chk("ready_return_timeout", 32'(ulaz_ready), 32'd1);
    ulaz_valid = 1'b0;
  endtask

  // kind: 0 good frame, 1 end marker on word 10, 2 no end marker on word N-1.
  task automatic send_frame(input int first, input logic [15:0] base, input bit rnd,
                            input logic [15:0] prob, input int kind, input int bmax, input int hold);
    int last;
    logic [15:0] d;
    logic z;
    wait_ready();
    izlaz_neurona = prob;
    cur_prob = prob;
    hold_req = hold;
    last = (kind == 1) ? 10 : N - 1;
    for (int i = first; i <= last; i++) begin
      d = rnd ? 16'($urandom) : base + 16'(i);
      z = (kind == 1) ? (i == 10) : ((kind == 0) && (i == N - 1));
      send_word(d, z, (bmax > 0) ? int'($urandom_range(0, bmax)) : 0);
    end
    tick();
    ulaz_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    edge_count <= edge_count + 1;
    rr_at_edge <= rez_ready;
  end

  // Downstream: holds rez_ready low for hold_req cycles of each result, random otherwise.
  initial begin
    rez_ready = 1'b0;
    forever begin
      tick();
      if (rez_valid === 1'b1) begin
        if (hold_cnt > 0) begin
          rez_ready = 1'b0;
          hold_cnt--;
        end else begin
          rez_ready = 1'b1;
        end
      end else begin
        rez_ready = 1'($urandom_range(0, 1));
        hold_cnt = hold_req;
      end
    end
  end

  logic           prev_valid = 1'b0;
  int             hs = 0;
  logic [N*W-1:0] exp_vec = '0;
  logic [15:0]    exp_p = 16'h0000;
  logic           exp_m = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    int ge;
    if (rst_n !== 1'b1) begin
      prev_valid = 1'b0;
      hs = 0;
    end else begin
      if (greska === 1'b1) begin
        if (greska_q.size() == 0) begin
          chk("greska_unexpected", 32'(greska), 32'd0);
        end else begin
          ge = greska_q.pop_front();
          chk("greska_edge", edge_count, ge);
        end
        hs = 0;
      end
      if (rez_valid === 1'b1 && !prev_valid) begin
        if (sb_q.size() == 0) begin
          chk("rez_valid_unexpected", 32'(rez_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          exp_vec = e.vec;
          exp_p = e.p;
          exp_m = e.m;
          chk_vec("uzorak", uzorak, exp_vec);
          chk("vjerojatnost", rez_vjerojatnost, exp_p);
          chk("mina", rez_mina, exp_m);
          chk("latencija", edge_count - e.edge_no, LAT);
          chk("broj_rijeci", hs, N);
        end
        hs = 0;
      end else if (rez_valid === 1'b1) begin
        chk_vec("uzorak_drzi", uzorak, exp_vec);
        chk("vjerojatnost_drzi", rez_vjerojatnost, exp_p);
        chk("mina_drzi", rez_mina, exp_m);
        chk("ulaz_ready_drzi", 32'(ulaz_ready), 32'd0);
      end
      if (prev_valid && rr_at_edge) begin
        chk("rez_valid_pad", 32'(rez_valid), 32'd0);
        chk("ulaz_ready_povrat", 32'(ulaz_ready), 32'd1);
      end
      if (ulaz_valid === 1'b1 && ulaz_ready === 1'b1) hs++;
      prev_valid = (rez_valid === 1'b1);
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk_vec({tag, "_uzorak"}, uzorak, '0);
    chk({tag, "_rez_valid"}, 32'(rez_valid), 32'd0);
    chk({tag, "_vjerojatnost"}, rez_vjerojatnost, 32'd0);
    chk({tag, "_mina"}, 32'(rez_mina), 32'd0);
    chk({tag, "_greska"}, 32'(greska), 32'd0);
    chk({tag, "_ulaz_ready"}, 32'(ulaz_ready), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    rst_n = 1'b0;
    ulaz_valid = 1'b0;
    ulaz_podatak = 16'h0000;
    ulaz_zadnji = 1'b0;
    izlaz_neurona = 16'h0000;
    model_reset();
    #1;
    chk_reset_outputs("por");
    repeat (2) @(negedge clk);
    chk("por_ready_low", 32'(ulaz_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("por_ready_high", 32'(ulaz_ready), 32'd1);

    // Back-to-back frame, mine detected.
    send_frame(0, 16'h0100, 1'b0, 16'h9000, 0, 0, 0);
    // Same frame, no mine, result held under backpressure.
    send_frame(0, 16'h0100, 1'b0, 16'h7FFF, 0, 0, 5);
    // Valid bubbles at roughly half duty.
    send_frame(0, 16'h0100, 1'b0, 16'h9000, 0, 1, 1);
    // Early end marker, then a good frame at the threshold boundary.
    send_frame(0, 16'h0A00, 1'b0, 16'h1234, 1, 0, 0);
    send_frame(0, 16'h0B00, 1'b0, 16'h8000, 0, 0, 2);
    // Missing end marker; the next word must land in slot 0.
    send_frame(0, 16'h0C00, 1'b0, 16'h4321, 2, 0, 0);
    send_word(16'hBEEF, 1'b0, 0);
    tick();
    ulaz_valid = 1'b0;
    chk("slot0_after_error", uzorak[15:0], 32'h0000BEEF);
    send_frame(1, 16'h0200, 1'b0, 16'h8001, 0, 1, 0);

    for (int f = 0; f < 6; f++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      if (kind == 3) kind = 0;
      send_frame(0, 16'h0000, 1'b1, 16'($urandom), kind, 1, int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of a frame.
    wait_ready();
    for (int i = 0; i <= 30; i++) send_word(16'h0300 + 16'(i), 1'b0, 0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    model_reset();
    ulaz_valid = 1'b1;
    ulaz_podatak = 16'hDEAD;
    ulaz_zadnji = 1'b1;
    repeat (3) tick();
    chk("reset_ready_low", 32'(ulaz_ready), 32'd0);
    chk_vec("reset_uzorak_held", uzorak, '0);
    @(negedge clk);
    rst_n = 1'b1;
    ulaz_valid = 1'b0;
    #1;
    chk("release_ready_low", 32'(ulaz_ready), 32'd0);
    tick();
    chk("release_ready_high", 32'(ulaz_ready), 32'd1);
    send_frame(0, 16'h0400, 1'b0, 16'hFFFF, 0, 0, 1);

    b = 0;
    while ((sb_q.size() != 0 || greska_q.size() != 0) && b < 300) begin
      tick();
      b++;
    end
    repeat (5) tick();
    chk("scoreboard_drained", sb_q.size() + greska_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
